// File: rtl/sevenseg_pkg.sv
// Shared constants for seven-segment display paths: segment bit positions,
// the hex glyph table (active-high, bit order {g,f,e,d,c,b,a}) and the blank glyph.
package sevenseg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All segments dark, active-high.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Packed so that SEG_TABLE[n] is the glyph for nibble n (index 15 is leftmost).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,  // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,  // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,  // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F   // 3 2 1 0
  };

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to active-high {g,f,e,d,c,b,a} segment pattern.
// Kept polarity-neutral so any display path can reuse it.
module hex7seg_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with a double-buffered input
// (new data becomes visible only at a frame boundary), per-digit enable,
// optional leading-zero blanking and configurable pin polarities.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int LZ_BLANK       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             SEG_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic             AN_INV   = (AN_ACTIVE_LOW != 0);
  localparam logic             LZ_ON    = (LZ_BLANK != 0);
  // Unlit / unselected pin levels after polarity.
  localparam logic [6:0]            SEG_OFF = SEG_INV ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_INV;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_INV ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d, act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic                    pending_q, pending_d;
  logic                    frame_done_q, frame_done_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                  tick_s, wrap_s;
  logic [NUM_DIGITS-1:0] sel_s, lz_s;
  logic [3:0]            cur_nib_s;
  logic                  cur_dp_s, cur_blank_s;
  logic [6:0]            cur_seg_s;

  // Prescaler and digit index: the index advances once per REFRESH_DIV clocks.
  always_comb begin
    tick_s = (cnt_q == CNT_LAST);
    wrap_s = tick_s && (idx_q == IDX_LAST);
    cnt_d  = tick_s ? {CNT_W{1'b0}} : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (wrap_s) begin
      idx_d = {IDX_W{1'b0}};
    end else if (tick_s) begin
      idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      idx_d = idx_q;
    end
    frame_done_d = wrap_s;
  end

  // Shadow/active buffering: a load parks data in the shadow until the frame
  // boundary; a load landing exactly on the boundary bypasses the shadow.
  always_comb begin
    sh_digits_d  = sh_digits_q;
    sh_dp_d      = sh_dp_q;
    sh_en_d      = sh_en_q;
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    pending_d    = pending_q;
    if (load) begin
      sh_digits_d = digits_in;
      sh_dp_d     = dp_in;
      sh_en_d     = digit_en;
    end else begin
      sh_digits_d = sh_digits_q;
    end
    if (wrap_s && load) begin
      act_digits_d = digits_in;
      act_dp_d     = dp_in;
      act_en_d     = digit_en;
      pending_d    = 1'b0;
    end else if (wrap_s && pending_q) begin
      act_digits_d = sh_digits_q;
      act_dp_d     = sh_dp_q;
      act_en_d     = sh_en_q;
      pending_d    = 1'b0;
    end else if (load) begin
      pending_d    = 1'b1;
    end else begin
      pending_d    = pending_q;
    end
  end

  // Current-slot selection and leading-zero detection. A digit is a leading
  // zero when it and every enabled digit above it are 0; disabled digits above
  // are transparent. Digit 0 is never treated as a leading zero.
  always_comb begin
    logic zero_above;
    zero_above  = 1'b1;
    sel_s       = {NUM_DIGITS{1'b0}};
    lz_s        = {NUM_DIGITS{1'b0}};
    cur_nib_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_blank_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_s[i]    = LZ_ON && (i > 0) && zero_above && (act_digits_q[4*i +: 4] == 4'h0);
      zero_above = zero_above && (!act_en_q[i] || (act_digits_q[4*i +: 4] == 4'h0));
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_s[i]    = (idx_q == IDX_W'(i));
      cur_nib_s   = cur_nib_s | (act_digits_q[4*i +: 4] & {4{sel_s[i]}});
      cur_dp_s    = cur_dp_s | (act_dp_q[i] & sel_s[i]);
      cur_blank_s = cur_blank_s & ~(sel_s[i] & act_en_q[i] & ~lz_s[i]);
    end
  end

  hex7seg_decoder u_dec (
    .nibble (cur_nib_s),
    .seg    (cur_seg_s)
  );

  // Next output pin levels; polarity is applied only here.
  always_comb begin
    logic [6:0]            seg_hi;
    logic                  dp_hi;
    logic [NUM_DIGITS-1:0] an_hi;
    seg_hi = cur_blank_s ? SEG_BLANK : cur_seg_s;
    dp_hi  = ~cur_blank_s & cur_dp_s;
    an_hi  = cur_blank_s ? {NUM_DIGITS{1'b0}} : sel_s;
    seg_d  = SEG_INV ? ~seg_hi : seg_hi;
    dp_d   = SEG_INV ? ~dp_hi : dp_hi;
    an_d   = AN_INV ? ~an_hi : an_hi;
  end

  // Scan counters and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= {CNT_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Shadow and active display buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits_q  <= {(4*NUM_DIGITS){1'b0}};
      sh_dp_q      <= {NUM_DIGITS{1'b0}};
      sh_en_q      <= {NUM_DIGITS{1'b0}};
      act_digits_q <= {(4*NUM_DIGITS){1'b0}};
      act_dp_q     <= {NUM_DIGITS{1'b0}};
      act_en_q     <= {NUM_DIGITS{1'b0}};
      pending_q    <= 1'b0;
    end else begin
      sh_digits_q  <= sh_digits_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      act_digits_q <= act_digits_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      pending_q    <= pending_d;
    end
  end

  // Registered display pins; reset parks them at the unlit/unselected level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg            = seg_q;
  assign dp             = dp_q;
  assign an             = an_q;
  assign frame_done     = frame_done_q;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench: two drivers (leading-zero blanking off / on) share the
// same stimulus. The stimulus process pushes the hand-computed picture of each
// upcoming frame; the monitor pops one on every frame_done and samples each
// digit slot mid-way.
module tb_sevenseg_scan_driver;

  localparam logic [6:0] BLK = 7'h7F;  // blank slot: seg dark, an all 1, dp 1

  typedef struct packed {
    logic [1:0][3:0][3:0] an;
    logic [1:0][3:0][6:0] seg;
    logic [1:0][3:0]      dp;
    logic [3:0]           pend;
  } frame_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic        load = 1'b0;

  logic [6:0] seg_w [2];
  logic       dp_w  [2];
  logic [3:0] an_w  [2];
  logic       fd_w  [2];
  logic       upd_w [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  frame_exp_t exp_q[$];

  sevenseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1),
                         .AN_ACTIVE_LOW(1), .LZ_BLANK(0)) dut_plain (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .digit_en(digit_en), .load(load), .seg(seg_w[0]), .dp(dp_w[0]),
    .an(an_w[0]), .frame_done(fd_w[0]), .update_pending(upd_w[0]));

  sevenseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1),
                         .AN_ACTIVE_LOW(1), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .digit_en(digit_en), .load(load), .seg(seg_w[1]), .dp(dp_w[1]),
    .an(an_w[1]), .frame_done(fd_w[1]), .update_pending(upd_w[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic void slot(inout frame_exp_t e, input int d, input int j,
                               input logic [6:0] s, input logic p);
    logic [3:0] one;
    one = 4'b0001;
    e.seg[d][j] = s;
    e.an[d][j]  = (s == BLK) ? 4'hF : ~(one << j);
    e.dp[d][j]  = (s == BLK) ? 1'b1 : p;
  endfunction

  // segs = {slot3, slot2, slot1, slot0}; dpv bit j = dp pin level in slot j.
  function automatic void quad(inout frame_exp_t e, input int d,
                               input logic [27:0] segs, input logic [3:0] dpv);
    for (int j = 0; j < 4; j++) slot(e, d, j, segs[7*j +: 7], dpv[j]);
  endfunction

  // Hand-computed picture of each scripted frame (active-low pins).
  function automatic frame_exp_t exp_frame(input int f);
    frame_exp_t e;
    logic [27:0] s0, s1;
    logic [3:0]  dpv;
    e = '0;
    s0 = {BLK, BLK, BLK, BLK}; s1 = s0; dpv = 4'hF; e.pend = 4'b1100;
    case (f)
      0:  begin s0 = {BLK, BLK, BLK, BLK}; s1 = s0; end
      1:  begin s0 = {7'h79, 7'h24, 7'h30, 7'h19}; s1 = s0; dpv = 4'b1011; e.pend = 4'b0000; end
      2:  begin s0 = {7'h79, 7'h24, 7'h30, 7'h19}; s1 = s0; dpv = 4'b1011; end
      3:  begin s0 = {7'h08, 7'h08, 7'h08, 7'h08}; s1 = s0; end
      4:  begin s0 = {7'h40, 7'h40, 7'h12, 7'h40}; s1 = {BLK, BLK, 7'h12, 7'h40}; end
      5:  begin s0 = {7'h40, 7'h40, 7'h40, 7'h40}; s1 = {BLK, BLK, BLK, 7'h40}; e.pend = 4'b0000; end
      6:  begin s0 = {7'h10, 7'h10, 7'h10, 7'h10}; s1 = s0; end
      7:  begin s0 = {7'h40, BLK, 7'h24, 7'h30}; s1 = {BLK, BLK, 7'h24, 7'h30}; end
      8:  begin s0 = {7'h19, 7'h12, 7'h02, 7'h78}; s1 = s0; dpv = 4'h0; end
      9:  begin s0 = {7'h00, 7'h10, 7'h08, 7'h03}; s1 = s0; end
      10: begin s0 = {7'h46, 7'h21, 7'h06, 7'h0E}; s1 = s0; end
      11: begin s0 = {7'h30, 7'h40, 7'h40, 7'h40}; s1 = s0; e.pend = 4'b0000; end
      default: begin s0 = {BLK, BLK, BLK, BLK}; s1 = s0; end
    endcase
    quad(e, 0, s0, dpv);
    quad(e, 1, s1, dpv);
    return e;
  endfunction

  // Monitor: on each frame_done, pop the expected frame and sample every slot.
  initial begin : monitor
    int last_fd;
    frame_exp_t e;
    last_fd = -1;
    forever begin
      @(negedge clk);
      if (rst_n && fd_w[0]) begin
        chk("frame_done_pair", fd_w[1], 1);
        if (last_fd >= 0) chk("frame_period", cyc - last_fd, 16);
        last_fd = cyc;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          @(negedge clk);
          chk("frame_done_width", fd_w[0], 0);
          for (int j = 0; j < 4; j++) begin
            repeat ((j == 0) ? 1 : 4) @(negedge clk);
            for (int d = 0; d < 2; d++) begin
              chk($sformatf("an dut%0d slot%0d", d, j), an_w[d], e.an[d][j]);
              chk($sformatf("seg dut%0d slot%0d", d, j), seg_w[d], e.seg[d][j]);
              chk($sformatf("dp dut%0d slot%0d", d, j), dp_w[d], e.dp[d][j]);
              chk($sformatf("pending dut%0d slot%0d", d, j), upd_w[d], e.pend[j]);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Per-frame actions: 0 none, 1 load mid-frame, 2 load on wrap tick, 3 two loads.
  int          act_a [12] = '{1, 0, 1, 1, 1, 2, 1, 1, 1, 1, 3, 0};
  logic [15:0] dat_a [12] = '{16'h1234, 16'h0, 16'hAAAA, 16'h0050, 16'h0000, 16'h9999,
                              16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h1111, 16'h0};
  logic [3:0]  en_a  [12] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                              4'b1011, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [3:0]  dp_a  [12] = '{4'b0100, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                              4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};

  task automatic drive(input logic [15:0] dv, input logic [3:0] ev, input logic [3:0] pv);
    digits_in = dv; digit_en = ev; dp_in = pv; load = 1'b1;
  endtask

  initial begin : stimulus
    bit seen;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset seg dut%0d", d), seg_w[d], 7'h7F);
      chk($sformatf("reset dp dut%0d", d), dp_w[d], 1);
      chk($sformatf("reset an dut%0d", d), an_w[d], 4'hF);
      chk($sformatf("reset frame_done dut%0d", d), fd_w[d], 0);
      chk($sformatf("reset pending dut%0d", d), upd_w[d], 0);
    end
    repeat (3) @(negedge clk);
    exp_q.push_back(exp_frame(0));
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = fd_w[0];
    end
    if (!seen) begin
      failures++;
      $display("FAIL first_frame_done: never seen within 200 cycles");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
    end
    for (int f = 0; f < 12; f++) begin
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        if (k == 1 && f < 11) exp_q.push_back(exp_frame(f + 1));
        if (k == 6 && (act_a[f] == 1 || act_a[f] == 3)) drive(dat_a[f], en_a[f], dp_a[f]);
        if (k == 7 || k == 11 || k == 16) load = 1'b0;
        if (k == 10 && act_a[f] == 3) drive(16'h3000, 4'hF, 4'h0);
        if (k == 15 && act_a[f] == 2) drive(dat_a[f], en_a[f], dp_a[f]);
      end
    end
    // Reset in the middle of a frame with a load still pending.
    repeat (6) @(negedge clk);
    drive(16'h5555, 4'hF, 4'h0);
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    chk("pending before reset dut0", upd_w[0], 1);
    chk("pending before reset dut1", upd_w[1], 1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midscan reset seg dut%0d", d), seg_w[d], 7'h7F);
      chk($sformatf("midscan reset dp dut%0d", d), dp_w[d], 1);
      chk($sformatf("midscan reset an dut%0d", d), an_w[d], 4'hF);
      chk($sformatf("midscan reset frame_done dut%0d", d), fd_w[d], 0);
      chk($sformatf("midscan reset pending dut%0d", d), upd_w[d], 0);
    end
    chk("scoreboard drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Parametrised successor to the calculator's per-segment combinational decoders. It takes NUM_DIGITS packed hex nibbles and drives a time-multiplexed common-anode/cathode seven-segment display. It decodes all seven segments plus the decimal point. Inputs are double-buffered so a new result appears only at a frame boundary, and leading-zero blanking is optional. It sits between the calculator datapath and the board's display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
REFRESH_DIV, 50000, clocks per digit slot (>=2)
SEG_ACTIVE_LOW, 1, 1: segment/dp pins drive 0 to light; 0: drive 1
AN_ACTIVE_LOW, 1, 1: digit-select pin 0 = selected; 0: 1 = selected
LZ_BLANK, 0, 1: blank leading zero digits (digit 0 never blanked)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
digits_in  in  4*NUM_DIGITS  hex nibbles; nibble i = digit i, digit 0 is rightmost
dp_in  in  NUM_DIGITS  decimal point per digit
digit_en  in  NUM_DIGITS  per-digit enable; 0 = blank
load  in  1  one-cycle strobe capturing digits_in/dp_in/digit_en into the shadow buffer
seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
an  out  NUM_DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW
frame_done  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0
update_pending  out  1  shadow buffer holds data not yet shown

Behaviour:
- Reset (async assert, sync deassert by the system): prescaler=0, idx=0, shadow and active buffers cleared (digit_en=0). Outputs go inactive: every segment, dp and an pin is at its unlit/unselected level (seg=7'h7F, dp=1, an all 1 for active-low). frame_done=0, update_pending=0. Reset mid-scan discards the frame and any pending load.
- Prescaler counts 0..REFRESH_DIV-1. tick=1 when cnt==REFRESH_DIV-1, then cnt returns to 0.
- On tick: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
- A wrap tick (idx==NUM_DIGITS-1) is the frame boundary:
  - frame_done=1 for exactly that cycle (registered, high in the cycle after the edge).
  - If update_pending, shadow copies to active and update_pending clears.
- load=1: shadow is captured and update_pending is set on the same edge. Repeated loads before a boundary overwrite the shadow; the last one wins.
- load coincident with the wrap tick: the incoming values go straight to active, and update_pending stays 0.
- Decode (active-high gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Blanking: a digit is blank if active digit_en[i]=0. With LZ_BLANK=1, a digit i>0 is also blank if it and every enabled digit above it are 0. A blank digit has its an pin inactive and seg/dp unlit.
- Outputs are registered from (idx, active buffer), with one clock of latency after an idx or active change. No glitch on an; exactly one an bit is active unless that digit is blank.
- Polarity is applied at the output register only.

Decomposition:
- Package sevenseg_pkg: 16-entry segment table constant (active-high gfedcba), segment bit-index constants SEG_A..SEG_G, and the blank pattern.
- Sub-module hex7seg_decoder: combinational nibble -> 7-bit active-high segments. It is reused by other display paths.
- The scan/buffer logic stays in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-scan with digits displayed -> same cycle seg=7'h7F, dp=1, an=4'hF, frame_done=0, update_pending=0.
- Decode sweep: NUM_DIGITS=1, REFRESH_DIV=2, load nibbles 0..F with digit_en=1 -> after the boundary seg=~table (9 -> 7'h10, 2 -> 7'h24, F -> 7'h0E).
- Scan timing: NUM_DIGITS=4, REFRESH_DIV=4, load 16'h1234, en=4'hF, dp=4'b0100 -> an cycles E,D,B,7, holding 4 clocks each. Slot an=E shows seg=7'h19. dp=0 only in slot an=B. frame_done pulses every 16 clocks.
- Double buffer: while showing 1234, load 16'hAAAA mid-frame -> update_pending=1, display stays 1234 until the wrap. The next frame shows A (seg=7'h08) on all digits and update_pending=0.
- Leading zeros: LZ_BLANK=1, load 16'h0050, en=F -> slots for digits 3 and 2 have an inactive. Digit 1 shows 5 (7'h12), digit 0 shows 0 (7'h40). Load 16'h0000 -> only digit 0 is lit.
- Coincident load at the wrap tick with 16'h9999 -> the next frame's first slot (an=E) shows 9 (7'h10), and update_pending never rises.
